// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and width helper shared by the serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/full_adder_structural.sv
// full_adder_structural: one-bit gate-level full adder.
module full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  logic p, g, t;
  xor (p, a, b);
  xor (sum, p, carry_in);
  and (g, a, b);
  and (t, p, carry_in);
  or  (carry_out, g, t);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit pair per clock LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             fa_s, fa_c, load, run, last;

  full_adder_structural u_fa (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .carry_in (carry_q),
    .sum      (fa_s),
    .carry_out(fa_c)
  );

  // sh_q holds WIDTH-1 partial bits; the final bit joins it directly into sum_q
  always_comb begin
    load    = start && (state_q != RUN);
    run     = state_q == RUN;
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = load ? RUN : (run && !last) ? RUN : (run && last) ? DONE : IDLE;
    a_d     = load ? a : run ? a_q >> 1 : a_q;
    b_d     = load ? b : run ? b_q >> 1 : b_q;
    carry_d = load ? cin : run ? fa_c : carry_q;
    cnt_d   = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    sh_d    = run ? (WIDTH-1)'({fa_s, sh_q} >> 1) : sh_q;
    sum_d   = (run && last) ? {fa_s, sh_q} : sum_q;
    cout_d  = (run && last) ? fa_c : cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench against an arithmetic reference.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  int           n_cmp = 0, n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One addition from acceptance to the done cycle; returns in the done cycle.
  task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                    input int poke, input bit keep);
    logic [W:0]   exp;
    logic [W-1:0] held_s;
    logic         held_c;
    int           lat, nbusy;
    bit           moved;
    exp    = (W+1)'(ai) + (W+1)'(bi) + (W+1)'(ci);
    held_s = sum;
    held_c = cout;
    a = ai; b = bi; cin = ci; start = 1'b1;
    step();
    chk("busy_after_accept", busy, 1);
    start = keep; lat = 0; nbusy = 0; moved = 0;
    while (!done && lat < 4 * W) begin
      if (busy) nbusy++;
      if (sum !== held_s || cout !== held_c) moved = 1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = keep || (lat == poke);
      if (lat == poke) begin a = 8'h11; b = 8'h22; end
      step();
      lat++;
    end
    start = keep;
    chk("latency", lat, W);
    chk("busy_cycles", nbusy, W);
    chk("out_held_in_run", moved, 0);
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
  endtask

  task automatic idle_watch(input int n, input logic [W-1:0] es, input logic ec, input string tag);
    int nd;
    bit moved;
    nd = 0; moved = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) nd++;
      if (sum !== es || cout !== ec) moved = 1;
    end
    chk({tag, "_no_extra_done"}, nd, 0);
    chk({tag, "_hold"}, moved, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    step();

    op(8'h00, 8'h00, 1'b0, -1, 1'b0);
    step();
    op(8'hFF, 8'h01, 1'b0, -1, 1'b0);
    start = 1'b0;
    idle_watch(5, 8'h00, 1'b1, "hold5");
    op(8'hA5, 8'h5A, 1'b1, -1, 1'b0);
    step();
    op(8'h3C, 8'h0F, 1'b0, -1, 1'b0);
    step();

    op(8'h12, 8'h34, 1'b0, 3, 1'b0);
    idle_watch(2 * W, 8'h46, 1'b0, "poke");

    a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    step(); step();
    rst_n = 1'b1;
    idle_watch(2 * W, 8'h00, 1'b0, "abort");
    op(8'h01, 8'h01, 1'b1, -1, 1'b0);
    step();

    op(8'h55, 8'h0A, 1'b0, -1, 1'b1);
    op(8'h80, 8'h80, 1'b0, -1, 1'b1);
    start = 1'b0;
    step();

    for (int k = 0; k < 40; k++) begin
      bit kp;
      kp = 1'($urandom);
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2 * W)), kp);
      if (!kp) for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    start = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
